// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Control-flow sequencer for a 5-stage RV32I pipeline. It arbitrates between
// an EX-stage redirect (taken branch or jump), the instruction-memory refill
// window that follows a redirect, and ID/EX load-use stalls. It drives the
// PC and IF/ID write enables, the pipeline flushes and the redirect target,
// and keeps two saturating performance counters.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,   // IF/ID-flush cycles after a redirect, 0..7
    parameter int CNT_W        = 32   // width of taken_cnt / stall_cnt
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             is_branch,
    input  logic [31:0]      branch_target,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    output logic             pc_we,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             busy,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Value loaded into the flush down-counter when a redirect opens a window.
    localparam int          FLUSH_INIT_I = (FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0;
    localparam logic [2:0]  FLUSH_INIT   = 3'(FLUSH_INIT_I);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic [2:0]       fcnt_q;
    logic [CNT_W-1:0] taken_q;
    logic [CNT_W-1:0] stall_q;

    logic take;
    logic lu;

    // Redirect request and load-use hazard detection (x0 loads never stall).
    always_comb begin
        take = ex_valid & is_branch;
        lu   = id_valid & ex_mem_read & (ex_rd != 5'd0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    end

    // Control outputs: priority take > flush window > load-use > normal flow.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_we       = 1'b0;
        pc_redirect = 1'b0;
        if_id_we    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst_n) begin
            if (take) begin
                pc_we       = 1'b1;
                pc_redirect = 1'b1;
                if_id_we    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (state_q == FLUSH) begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                if_id_flush = 1'b1;
            end else if (lu) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
            end
        end
    end

    // Status and counter outputs are forced to zero while reset is held.
    always_comb begin
        busy        = rst_n & (state_q == FLUSH);
        redirect_pc = rst_n ? branch_target : 32'd0;
        taken_cnt   = rst_n ? taken_q : '0;
        stall_cnt   = rst_n ? stall_q : '0;
    end

    // FSM, flush window counter and saturating perf counters.
    always_ff @(posedge clk) begin
        // NOTE: synchronous reset is sampled here, and all state uses <=.
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= 3'd0;
            taken_q <= '0;
            stall_q <= '0;
        end else if (take) begin
            if (taken_q != '1) begin
                taken_q <= taken_q + CNT_ONE;
            end
            if (FLUSH_CYCLES > 0) begin
                state_q <= FLUSH;
                fcnt_q  <= FLUSH_INIT;
            end else begin
                state_q <= RUN;
                fcnt_q  <= 3'd0;
            end
        end else if (state_q == FLUSH) begin
            if (fcnt_q == 3'd0) begin
                state_q <= RUN;
            end else begin
                fcnt_q <= fcnt_q - 3'd1;
            end
        end else if (lu) begin
            if (stall_q != '1) begin
                stall_q <= stall_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Three instances share one stimulus stream: (FLUSH_CYCLES=1, CNT_W=32),
// (0, 4) and (3, 8). A reference model tracks the remaining flush cycles and
// the counter values as plain integers and predicts every output each cycle.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ex_valid;
    logic        is_branch;
    logic [31:0] branch_target;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;

    logic        pc_we [3];
    logic        pc_redirect [3];
    logic [31:0] redirect_pc [3];
    logic        if_id_we [3];
    logic        if_id_flush [3];
    logic        id_ex_flush [3];
    logic        busy [3];
    logic [31:0] tc0, sc0;
    logic [3:0]  tc1, sc1;
    logic [7:0]  tc2, sc2;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .is_branch(is_branch),
        .branch_target(branch_target), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .pc_we(pc_we[0]),
        .pc_redirect(pc_redirect[0]), .redirect_pc(redirect_pc[0]),
        .if_id_we(if_id_we[0]), .if_id_flush(if_id_flush[0]),
        .id_ex_flush(id_ex_flush[0]), .busy(busy[0]),
        .taken_cnt(tc0), .stall_cnt(sc0)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(0), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .is_branch(is_branch),
        .branch_target(branch_target), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .pc_we(pc_we[1]),
        .pc_redirect(pc_redirect[1]), .redirect_pc(redirect_pc[1]),
        .if_id_we(if_id_we[1]), .if_id_flush(if_id_flush[1]),
        .id_ex_flush(id_ex_flush[1]), .busy(busy[1]),
        .taken_cnt(tc1), .stall_cnt(sc1)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .is_branch(is_branch),
        .branch_target(branch_target), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .pc_we(pc_we[2]),
        .pc_redirect(pc_redirect[2]), .redirect_pc(redirect_pc[2]),
        .if_id_we(if_id_we[2]), .if_id_flush(if_id_flush[2]),
        .id_ex_flush(id_ex_flush[2]), .busy(busy[2]),
        .taken_cnt(tc2), .stall_cnt(sc2)
    );

    // Reference model: flush cycles still owed and counter values per instance.
    int     fc   [3] = '{1, 0, 3};
    longint cmax [3] = '{64'hFFFF_FFFF, 15, 255};
    int     fl   [3] = '{0, 0, 0};
    longint tk   [3] = '{0, 0, 0};
    longint st   [3] = '{0, 0, 0};

    int checks   = 0;
    int failures = 0;

    function automatic bit m_take();
        return ex_valid && is_branch;
    endfunction

    function automatic bit m_lu();
        bit hit1, hit2;
        hit1 = id_use_rs1 && (id_rs1 == ex_rd);
        hit2 = id_use_rs2 && (id_rs2 == ex_rd);
        return id_valid && ex_mem_read && (ex_rd != 0) && (hit1 || hit2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Predicted {pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_flush, busy}.
    function automatic logic [5:0] m_ctl(input int k);
        if (!rst_n)         return 6'b000000;
        else if (m_take())  return {5'b11111, fl[k] > 0};
        else if (fl[k] > 0) return 6'b101101;
        else if (m_lu())    return 6'b000010;
        else                return 6'b101000;
    endfunction

    task automatic compare_all();
        logic [31:0] otc, osc;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin otc = tc0;      osc = sc0;      end
                1:       begin otc = 32'(tc1); osc = 32'(sc1); end
                default: begin otc = 32'(tc2); osc = 32'(sc2); end
            endcase
            check($sformatf("ctl%0d", k),
                  32'({pc_we[k], pc_redirect[k], if_id_we[k], if_id_flush[k], id_ex_flush[k], busy[k]}),
                  32'(m_ctl(k)));
            check($sformatf("rpc%0d", k), redirect_pc[k], rst_n ? branch_target : 32'd0);
            check($sformatf("taken%0d", k), otc, rst_n ? 32'(tk[k]) : 32'd0);
            check($sformatf("stall%0d", k), osc, rst_n ? 32'(st[k]) : 32'd0);
        end
    endtask

    // Let inputs settle and compare everything against the model.
    task automatic settle();
        #1;
        compare_all();
    endtask

    // Clock edge: advance the model with the inputs seen at the edge.
    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                fl[k] = 0; tk[k] = 0; st[k] = 0;
            end else if (m_take()) begin
                fl[k] = fc[k];
                if (tk[k] < cmax[k]) tk[k]++;
            end else if (fl[k] > 0) begin
                fl[k]--;
            end else if (m_lu()) begin
                if (st[k] < cmax[k]) st[k]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle();
        rst_n = 1'b1; ex_valid = 1'b0; is_branch = 1'b0; branch_target = $urandom;
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        id_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = 5'd5;
        id_use_rs2 = 1'b1; id_rs1 = 5'd9; id_use_rs1 = 1'b0;
    endtask

    initial begin
        idle();
        // Reset held 3 cycles with a redirect request present.
        rst_n = 1'b0; ex_valid = 1'b1; is_branch = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("rst_pc_we", 32'(pc_we[0]), 32'd0);
            check("rst_taken", tc0, 32'd0);
            advance();
        end
        idle();
        settle();
        check("rel_pc_we", 32'(pc_we[0]), 32'd1);
        check("rel_busy", 32'(busy[0]), 32'd0);
        advance();

        // Redirect to 0x100 with a one-cycle flush window.
        ex_valid = 1'b1; is_branch = 1'b1; branch_target = 32'h0000_0100;
        settle();
        check("t2_redir", 32'(pc_redirect[0]), 32'd1);
        check("t2_rpc", redirect_pc[0], 32'h0000_0100);
        check("t2_flush", 32'({if_id_flush[0], id_ex_flush[0]}), 32'd3);
        advance();
        idle();
        settle();
        check("t2_busy", 32'(busy[0]), 32'd1);
        check("t2_ifflush", 32'(if_id_flush[0]), 32'd1);
        check("t2_noredir", 32'(pc_redirect[0]), 32'd0);
        advance();
        settle();
        check("t2_run", 32'(busy[0]), 32'd0);
        check("t2_taken", tc0, 32'd1);
        advance();
        for (int i = 0; i < 4; i++) tick();

        // Load-use stall on rs2, then an x0 load that must not stall.
        set_lu(5'd5);
        settle();
        check("t3_pc_we", 32'(pc_we[0]), 32'd0);
        check("t3_ifid_we", 32'(if_id_we[0]), 32'd0);
        check("t3_idex", 32'(id_ex_flush[0]), 32'd1);
        advance();
        idle();
        settle();
        check("t3_once", 32'(id_ex_flush[0]), 32'd0);
        check("t3_stall", sc0, 32'd1);
        advance();
        set_lu(5'd0); id_rs2 = 5'd0;
        settle();
        check("t3_x0", 32'(pc_we[0]), 32'd1);
        advance();

        // Redirect and load-use together: redirect wins, no stall counted.
        set_lu(5'd5); ex_valid = 1'b1; is_branch = 1'b1;
        settle();
        check("t4_pc_we", 32'(pc_we[0]), 32'd1);
        check("t4_redir", 32'(pc_redirect[0]), 32'd1);
        advance();
        idle();
        settle();
        check("t4_stall", sc0, 32'd1);
        advance();
        for (int i = 0; i < 4; i++) tick();

        // Load-use inside the flush window is ignored.
        ex_valid = 1'b1; is_branch = 1'b1;
        advance();
        idle(); set_lu(5'd5);
        settle();
        check("t5_pc_we", 32'(pc_we[0]), 32'd1);
        check("t5_busy", 32'(busy[0]), 32'd1);
        check("t5_idex", 32'(id_ex_flush[0]), 32'd0);
        advance();
        idle();
        settle();
        check("t5_stall", sc0, 32'd1);
        advance();
        // Reset for one cycle inside a flush window.
        ex_valid = 1'b1; is_branch = 1'b1;
        advance();
        idle(); rst_n = 1'b0;
        tick();
        idle();
        settle();
        check("t5_rst_busy", 32'(busy[0]), 32'd0);
        check("t5_rst_taken", tc0, 32'd0);
        check("t5_rst_stall", sc0, 32'd0);
        advance();

        // 20 back-to-back redirects: 4-bit counter saturates, no flush window.
        for (int i = 0; i < 20; i++) begin
            ex_valid = 1'b1; is_branch = 1'b1; branch_target = $urandom;
            settle();
            check("t6_busy", 32'(busy[1]), 32'd0);
            advance();
        end
        idle();
        settle();
        check("t6_sat", 32'(tc1), 32'd15);
        advance();

        // Randomized traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            rst_n         = ($urandom_range(0, 79) != 0);
            ex_valid      = ($urandom_range(0, 3) != 0);
            is_branch     = ($urandom_range(0, 4) == 0);
            branch_target = $urandom;
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_use_rs1    = 1'($urandom);
            id_use_rs2    = 1'($urandom);
            ex_mem_read   = ($urandom_range(0, 1) != 0);
            ex_rd         = 5'($urandom_range(0, 3));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
